mem_arbiter_ysyx23060136: RTL and testbench

Arbitrates the single memory port between the instruction-fetch unit and the load/store unit. It accepts one request at a time from either requester and forwards it to memory. It then returns the response only to the requester that owns the transaction. It sits between the fetch/load-store stages and the memory model, and implements the ARBITER_IFU_* and ARBITER_LSU_* handshakes.

---
 rtl/DEFINES_ysyx23060136.sv | 25 ++
 rtl/mem_arbiter_ysyx23060136.sv | 114 +++++++++++
 tb/tb_mem_arbiter_ysyx23060136.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/DEFINES_ysyx23060136.sv
// Shared types and constants for the memory arbiter and its neighbours.
package DEFINES_ysyx23060136;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        IFU_REQ  = 3'd1,
        IFU_RESP = 3'd2,
        LSU_REQ  = 3'd3,
        LSU_RESP = 3'd4
    } arb_state_t;

    localparam logic [3:0] WSTRB_FULL = 4'b1111;
    localparam logic [3:0] WSTRB_NONE = 4'b0000;

    // Fixed priority: the data access belongs to an older instruction than the fetch.
    function automatic arb_state_t pick_grant(input logic lsu_valid, input logic ifu_valid);
        if (lsu_valid) begin
            return LSU_REQ;
        end else if (ifu_valid) begin
            return IFU_REQ;
        end
        return IDLE;
    endfunction

endpackage

// File: rtl/mem_arbiter_ysyx23060136.sv
// Shares one memory port between fetch and load/store, one transaction at a time, LSU first.
// Latency: grant registered (request in IDLE at N -> MEM_req_valid at N+1); response path adds 0 cycles.
// Backpressure: MEM_req_ready / owner's response ready are passed straight through to the other side.
module mem_arbiter_ysyx23060136
    import DEFINES_ysyx23060136::*;
(
    input  logic        clk,
    input  logic        rst,

    input  logic [31:0] ARBITER_IFU_pc,
    input  logic        ARBITER_IFU_pc_valid,
    output logic        ARBITER_IFU_pc_ready,
    output logic [31:0] ARBITER_IFU_inst,
    output logic        ARBITER_IFU_inst_valid,
    input  logic        ARBITER_IFU_inst_ready,

    input  logic [31:0] ARBITER_LSU_addr,
    input  logic        ARBITER_LSU_wen,
    input  logic [31:0] ARBITER_LSU_wdata,
    input  logic [3:0]  ARBITER_LSU_wstrb,
    input  logic        ARBITER_LSU_valid,
    output logic        ARBITER_LSU_ready,
    output logic [31:0] ARBITER_LSU_rdata,
    output logic        ARBITER_LSU_rvalid,
    input  logic        ARBITER_LSU_rready,

    output logic [31:0] MEM_req_addr,
    output logic        MEM_req_wen,
    output logic [31:0] MEM_req_wdata,
    output logic [3:0]  MEM_req_wstrb,
    output logic        MEM_req_valid,
    input  logic        MEM_req_ready,
    input  logic [31:0] MEM_resp_rdata,
    input  logic        MEM_resp_valid,
    output logic        MEM_resp_ready
);

    arb_state_t state;
    arb_state_t state_nxt;
    logic       lsu_is_write;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Writes answer with zero data, so remember the direction of the accepted LSU access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lsu_is_write <= 1'b0;
        end else if (state == LSU_REQ && MEM_req_ready) begin
            lsu_is_write <= ARBITER_LSU_wen;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:     state_nxt = pick_grant(ARBITER_LSU_valid, ARBITER_IFU_pc_valid);
            IFU_REQ:  if (MEM_req_ready) state_nxt = IFU_RESP;
            LSU_REQ:  if (MEM_req_ready) state_nxt = LSU_RESP;
            IFU_RESP: if (MEM_resp_valid && ARBITER_IFU_inst_ready)
                          state_nxt = pick_grant(ARBITER_LSU_valid, ARBITER_IFU_pc_valid);
            LSU_RESP: if (MEM_resp_valid && ARBITER_LSU_rready)
                          state_nxt = pick_grant(ARBITER_LSU_valid, ARBITER_IFU_pc_valid);
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ARBITER_IFU_pc_ready   = 1'b0;
        ARBITER_IFU_inst       = 32'h0;
        ARBITER_IFU_inst_valid = 1'b0;
        ARBITER_LSU_ready      = 1'b0;
        ARBITER_LSU_rdata      = 32'h0;
        ARBITER_LSU_rvalid     = 1'b0;
        MEM_req_addr           = 32'h0;
        MEM_req_wen            = 1'b0;
        MEM_req_wdata          = 32'h0;
        MEM_req_wstrb          = WSTRB_NONE;
        MEM_req_valid          = 1'b0;
        MEM_resp_ready         = 1'b0;
        unique case (state)
            IFU_REQ: begin
                MEM_req_addr         = ARBITER_IFU_pc;
                MEM_req_valid        = 1'b1;
                ARBITER_IFU_pc_ready = MEM_req_ready;
            end
            IFU_RESP: begin
                ARBITER_IFU_inst       = MEM_resp_rdata;
                ARBITER_IFU_inst_valid = MEM_resp_valid;
                MEM_resp_ready         = ARBITER_IFU_inst_ready;
            end
            LSU_REQ: begin
                MEM_req_addr      = ARBITER_LSU_addr;
                MEM_req_wen       = ARBITER_LSU_wen;
                MEM_req_wdata     = ARBITER_LSU_wdata;
                MEM_req_wstrb     = ARBITER_LSU_wstrb;
                MEM_req_valid     = 1'b1;
                ARBITER_LSU_ready = MEM_req_ready;
            end
            LSU_RESP: begin
                ARBITER_LSU_rdata  = lsu_is_write ? 32'h0 : MEM_resp_rdata;
                ARBITER_LSU_rvalid = MEM_resp_valid;
                MEM_resp_ready     = ARBITER_LSU_rready;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter_ysyx23060136.sv
// Directed bench for the memory arbiter with a transaction-level reference model.
module tb_mem_arbiter_ysyx23060136;

    logic        clk;
    logic        rst;
    logic [31:0] ARBITER_IFU_pc;
    logic        ARBITER_IFU_pc_valid;
    logic        ARBITER_IFU_pc_ready;
    logic [31:0] ARBITER_IFU_inst;
    logic        ARBITER_IFU_inst_valid;
    logic        ARBITER_IFU_inst_ready;
    logic [31:0] ARBITER_LSU_addr;
    logic        ARBITER_LSU_wen;
    logic [31:0] ARBITER_LSU_wdata;
    logic [3:0]  ARBITER_LSU_wstrb;
    logic        ARBITER_LSU_valid;
    logic        ARBITER_LSU_ready;
    logic [31:0] ARBITER_LSU_rdata;
    logic        ARBITER_LSU_rvalid;
    logic        ARBITER_LSU_rready;
    logic [31:0] MEM_req_addr;
    logic        MEM_req_wen;
    logic [31:0] MEM_req_wdata;
    logic [3:0]  MEM_req_wstrb;
    logic        MEM_req_valid;
    logic        MEM_req_ready;
    logic [31:0] MEM_resp_rdata;
    logic        MEM_resp_valid;
    logic        MEM_resp_ready;

    int n_chk  = 0;
    int n_fail = 0;
    int req_hs = 0;
    int hs0;
    int iso_seen;

    mem_arbiter_ysyx23060136 dut (
        .clk(clk), .rst(rst),
        .ARBITER_IFU_pc(ARBITER_IFU_pc), .ARBITER_IFU_pc_valid(ARBITER_IFU_pc_valid),
        .ARBITER_IFU_pc_ready(ARBITER_IFU_pc_ready), .ARBITER_IFU_inst(ARBITER_IFU_inst),
        .ARBITER_IFU_inst_valid(ARBITER_IFU_inst_valid), .ARBITER_IFU_inst_ready(ARBITER_IFU_inst_ready),
        .ARBITER_LSU_addr(ARBITER_LSU_addr), .ARBITER_LSU_wen(ARBITER_LSU_wen),
        .ARBITER_LSU_wdata(ARBITER_LSU_wdata), .ARBITER_LSU_wstrb(ARBITER_LSU_wstrb),
        .ARBITER_LSU_valid(ARBITER_LSU_valid), .ARBITER_LSU_ready(ARBITER_LSU_ready),
        .ARBITER_LSU_rdata(ARBITER_LSU_rdata), .ARBITER_LSU_rvalid(ARBITER_LSU_rvalid),
        .ARBITER_LSU_rready(ARBITER_LSU_rready),
        .MEM_req_addr(MEM_req_addr), .MEM_req_wen(MEM_req_wen), .MEM_req_wdata(MEM_req_wdata),
        .MEM_req_wstrb(MEM_req_wstrb), .MEM_req_valid(MEM_req_valid), .MEM_req_ready(MEM_req_ready),
        .MEM_resp_rdata(MEM_resp_rdata), .MEM_resp_valid(MEM_resp_valid), .MEM_resp_ready(MEM_resp_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic        pc_ready;
        logic [31:0] inst;
        logic        inst_valid;
        logic        lsu_ready;
        logic [31:0] lsu_rdata;
        logic        lsu_rvalid;
        logic [31:0] req_addr;
        logic        req_wen;
        logic [31:0] req_wdata;
        logic [3:0]  req_wstrb;
        logic        req_valid;
        logic        resp_ready;
    } out_t;

    out_t act_o;
    out_t exp_o;

    assign act_o = '{ARBITER_IFU_pc_ready, ARBITER_IFU_inst, ARBITER_IFU_inst_valid,
                     ARBITER_LSU_ready, ARBITER_LSU_rdata, ARBITER_LSU_rvalid,
                     MEM_req_addr, MEM_req_wen, MEM_req_wdata, MEM_req_wstrb,
                     MEM_req_valid, MEM_resp_ready};

    // Model: one outstanding transaction record (owner, accepted by memory yet, is-write).
    logic m_busy, m_lsu, m_sent, m_wr;
    wire  m_done = m_busy && m_sent && MEM_resp_valid &&
                   (m_lsu ? ARBITER_LSU_rready : ARBITER_IFU_inst_ready);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_lsu  <= 1'b0;
            m_sent <= 1'b0;
            m_wr   <= 1'b0;
        end else if (!m_busy || m_done) begin
            m_sent <= 1'b0;
            if (ARBITER_LSU_valid) begin
                m_busy <= 1'b1;
                m_lsu  <= 1'b1;
                m_wr   <= ARBITER_LSU_wen;
            end else if (ARBITER_IFU_pc_valid) begin
                m_busy <= 1'b1;
                m_lsu  <= 1'b0;
                m_wr   <= 1'b0;
            end else begin
                m_busy <= 1'b0;
            end
        end else if (!m_sent && MEM_req_ready) begin
            m_sent <= 1'b1;
        end
    end

    always_comb begin
        exp_o = '0;
        if (m_busy && !m_sent) begin
            exp_o.req_valid = 1'b1;
            if (m_lsu) begin
                exp_o.req_addr  = ARBITER_LSU_addr;
                exp_o.req_wen   = ARBITER_LSU_wen;
                exp_o.req_wdata = ARBITER_LSU_wdata;
                exp_o.req_wstrb = ARBITER_LSU_wstrb;
                exp_o.lsu_ready = MEM_req_ready;
            end else begin
                exp_o.req_addr = ARBITER_IFU_pc;
                exp_o.pc_ready = MEM_req_ready;
            end
        end else if (m_busy) begin
            if (m_lsu) begin
                exp_o.lsu_rdata  = m_wr ? 32'h0 : MEM_resp_rdata;
                exp_o.lsu_rvalid = MEM_resp_valid;
                exp_o.resp_ready = ARBITER_LSU_rready;
            end else begin
                exp_o.inst       = MEM_resp_rdata;
                exp_o.inst_valid = MEM_resp_valid;
                exp_o.resp_ready = ARBITER_IFU_inst_ready;
            end
        end
    end

    always @(negedge clk) begin
        n_chk++;
        if (act_o !== exp_o) begin
            n_fail++;
            $display("FAIL cycle_cmp t=%0t dut=%h model=%h", $time, act_o, exp_o);
        end
    end

    always @(posedge clk) begin
        if (!rst && MEM_req_valid && MEM_req_ready) req_hs++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ARBITER_IFU_pc         = 32'h0;
        ARBITER_IFU_pc_valid   = 1'b0;
        ARBITER_IFU_inst_ready = 1'b0;
        ARBITER_LSU_addr       = 32'h0;
        ARBITER_LSU_wen        = 1'b0;
        ARBITER_LSU_wdata      = 32'h0;
        ARBITER_LSU_wstrb      = 4'h0;
        ARBITER_LSU_valid      = 1'b0;
        ARBITER_LSU_rready     = 1'b0;
        MEM_req_ready          = 1'b0;
        MEM_resp_rdata         = 32'h0;
        MEM_resp_valid         = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b0;
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_req_valid", 32'(MEM_req_valid), 32'h0);
        chk("rst_inst_valid", 32'(ARBITER_IFU_inst_valid), 32'h0);
        chk("rst_lsu_rvalid", 32'(ARBITER_LSU_rvalid), 32'h0);
        step();
        rst = 1'b0;
        step();

        // Single fetch
        ARBITER_IFU_pc = 32'h8000_0000; ARBITER_IFU_pc_valid = 1'b1; ARBITER_IFU_inst_ready = 1'b1;
        @(negedge clk);
        chk("fetch_c0_req_valid", 32'(MEM_req_valid), 32'h0);
        step(); MEM_req_ready = 1'b1;
        @(negedge clk);
        chk("fetch_c1_req_addr", MEM_req_addr, 32'h8000_0000);
        chk("fetch_c1_pc_ready", 32'(ARBITER_IFU_pc_ready), 32'h1);
        step(); MEM_req_ready = 1'b0; ARBITER_IFU_pc_valid = 1'b0;
        @(negedge clk);
        chk("fetch_c2_inst_valid", 32'(ARBITER_IFU_inst_valid), 32'h0);
        step(); MEM_resp_valid = 1'b1; MEM_resp_rdata = 32'h0000_0413;
        @(negedge clk);
        chk("fetch_c3_inst", ARBITER_IFU_inst, 32'h0000_0413);
        chk("fetch_c3_inst_valid", 32'(ARBITER_IFU_inst_valid), 32'h1);
        step(); MEM_resp_valid = 1'b0;
        step();

        // Collision: LSU read wins, IFU follows straight after the LSU response handshake
        ARBITER_IFU_pc = 32'h8000_0004; ARBITER_IFU_pc_valid = 1'b1;
        ARBITER_LSU_addr = 32'h8000_1000; ARBITER_LSU_wen = 1'b0; ARBITER_LSU_valid = 1'b1;
        ARBITER_LSU_rready = 1'b1; MEM_req_ready = 1'b1;
        @(negedge clk);
        step();
        @(negedge clk);
        chk("coll_lsu_addr", MEM_req_addr, 32'h8000_1000);
        chk("coll_pc_ready", 32'(ARBITER_IFU_pc_ready), 32'h0);
        step(); ARBITER_LSU_valid = 1'b0; MEM_resp_valid = 1'b1; MEM_resp_rdata = 32'h1122_3344;
        @(negedge clk);
        chk("coll_lsu_rdata", ARBITER_LSU_rdata, 32'h1122_3344);
        chk("coll_lsu_rvalid", 32'(ARBITER_LSU_rvalid), 32'h1);
        step(); MEM_resp_valid = 1'b0;
        @(negedge clk);
        chk("coll_ifu_addr", MEM_req_addr, 32'h8000_0004);
        chk("coll_ifu_pc_ready", 32'(ARBITER_IFU_pc_ready), 32'h1);
        step(); ARBITER_IFU_pc_valid = 1'b0; MEM_req_ready = 1'b0;
        MEM_resp_valid = 1'b1; MEM_resp_rdata = 32'h0040_0093;
        @(negedge clk);
        chk("coll_ifu_inst", ARBITER_IFU_inst, 32'h0040_0093);
        step(); MEM_resp_valid = 1'b0;
        step();

        // LSU write
        ARBITER_LSU_addr = 32'h8000_2000; ARBITER_LSU_wen = 1'b1; ARBITER_LSU_wdata = 32'hDEAD_BEEF;
        ARBITER_LSU_wstrb = 4'b0011; ARBITER_LSU_valid = 1'b1; MEM_req_ready = 1'b1;
        @(negedge clk);
        step();
        @(negedge clk);
        chk("wr_addr", MEM_req_addr, 32'h8000_2000);
        chk("wr_wen", 32'(MEM_req_wen), 32'h1);
        chk("wr_wdata", MEM_req_wdata, 32'hDEAD_BEEF);
        chk("wr_wstrb", 32'(MEM_req_wstrb), 32'h3);
        step(); ARBITER_LSU_valid = 1'b0; MEM_req_ready = 1'b0;
        MEM_resp_valid = 1'b1; MEM_resp_rdata = 32'h0;
        @(negedge clk);
        chk("wr_rvalid", 32'(ARBITER_LSU_rvalid), 32'h1);
        chk("wr_rdata", ARBITER_LSU_rdata, 32'h0);
        step(); MEM_resp_valid = 1'b0; ARBITER_LSU_wen = 1'b0;
        step();

        // Backpressure on both request and response sides
        hs0 = req_hs;
        for (int i = 0; i < 13; i++) begin
            ARBITER_IFU_pc = 32'h8000_0008;
            ARBITER_IFU_pc_valid = (i <= 6);
            MEM_req_ready = (i == 6);
            MEM_resp_valid = (i >= 8 && i <= 11);
            MEM_resp_rdata = 32'h0010_0093;
            ARBITER_IFU_inst_ready = (i == 11);
            @(negedge clk);
            if (i >= 1 && i <= 5) chk("bp_req_addr", MEM_req_addr, 32'h8000_0008);
            if (i >= 8 && i <= 10) chk("bp_resp_ready", 32'(MEM_resp_ready), 32'h0);
            if (i == 11) chk("bp_inst", ARBITER_IFU_inst, 32'h0010_0093);
            step();
        end
        chk("bp_req_handshakes", 32'(req_hs - hs0), 32'h1);
        MEM_resp_valid = 1'b0;

        // Isolation: LSU toggles while IFU owns the port
        iso_seen = 0;
        ARBITER_LSU_addr = 32'h8000_3000;
        for (int i = 0; i < 10; i++) begin
            ARBITER_IFU_pc = 32'h8000_000C;
            ARBITER_IFU_pc_valid = (i <= 4);
            MEM_req_ready = (i == 4);
            MEM_resp_valid = (i == 8);
            MEM_resp_rdata = 32'h0000_0073;
            ARBITER_IFU_inst_ready = 1'b1;
            ARBITER_LSU_valid = (i >= 1 && i <= 7) ? i[0] : 1'b0;
            @(negedge clk);
            if (ARBITER_LSU_ready || ARBITER_LSU_rvalid) iso_seen++;
            if (i == 8) chk("iso_inst", ARBITER_IFU_inst, 32'h0000_0073);
            step();
        end
        chk("iso_lsu_outputs", 32'(iso_seen), 32'h0);
        idle_inputs();
        step();

        // Reset in IFU_RESP with a response on the bus
        ARBITER_IFU_pc = 32'h8000_0010; ARBITER_IFU_pc_valid = 1'b1; MEM_req_ready = 1'b1;
        @(negedge clk);
        step();
        @(negedge clk);
        step(); ARBITER_IFU_pc_valid = 1'b0; MEM_req_ready = 1'b0;
        MEM_resp_valid = 1'b1; MEM_resp_rdata = 32'hFFFF_FFFF; ARBITER_IFU_inst_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_inst_valid", 32'(ARBITER_IFU_inst_valid), 32'h0);
        chk("arst_inst", ARBITER_IFU_inst, 32'h0);
        chk("arst_resp_ready", 32'(MEM_resp_ready), 32'h0);
        @(negedge clk);
        step(); rst = 1'b0; MEM_resp_valid = 1'b0;
        step();

        // Fetch served normally after reset
        ARBITER_IFU_pc = 32'h8000_0014; ARBITER_IFU_pc_valid = 1'b1; MEM_req_ready = 1'b1;
        ARBITER_IFU_inst_ready = 1'b1;
        @(negedge clk);
        step();
        @(negedge clk);
        chk("post_rst_addr", MEM_req_addr, 32'h8000_0014);
        step(); ARBITER_IFU_pc_valid = 1'b0; MEM_req_ready = 1'b0;
        MEM_resp_valid = 1'b1; MEM_resp_rdata = 32'h0000_0013;
        @(negedge clk);
        chk("post_rst_inst", ARBITER_IFU_inst, 32'h0000_0013);
        chk("post_rst_inst_valid", 32'(ARBITER_IFU_inst_valid), 32'h1);
        step(); MEM_resp_valid = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
